// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded RV32I fields into instruction words and streams them into imem
module instr_encoder_loader #(
  parameter int DEPTH = 64,
  parameter int AW = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  localparam int WW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [6:0]    in_opcode,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [2:0]    in_fn3,
  input  logic          in_fn7_5,
  input  logic [11:0]   in_imm,
  input  logic [19:0]   in_imm_uj,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic [WW-1:0] words
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_next;
  logic fire, legal, restart;
  logic [31:0] enc;
  assign in_ready = state == LOAD;
  assign fire = in_valid & in_ready;
  assign restart = (state != LOAD) & start;
  assign busy = in_ready | imem_we;
  assign done = (state == DONE) & ~imem_we;
  // B and J immediates arrive in decoder order, so only a bit shuffle is needed here
  always_comb begin
    legal = 1'b1;
    enc = '0;
    case (in_opcode)
      7'b0110011: enc = {1'b0, in_fn7_5, 5'b0, in_rs2, in_rs1, in_fn3, in_rd, in_opcode};
      7'b0010011, 7'b0000011: enc = {in_imm, in_rs1, in_fn3, in_rd, in_opcode};
      7'b0100011: enc = {in_imm[11:5], in_rs2, in_rs1, in_fn3, in_imm[4:0], in_opcode};
      7'b1100011: enc = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_fn3, in_imm[3:0], in_imm[10], in_opcode};
      7'b1101111: enc = {in_imm_uj[19], in_imm_uj[9:0], in_imm_uj[10], in_imm_uj[18:11], in_rd, in_opcode};
      7'b0110111: enc = {in_imm_uj, in_rd, in_opcode};
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    state_next = restart ? LOAD : state;
    if (fire && (in_last || (legal && words == WW'(DEPTH - 1)))) state_next = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we <= 1'b0;
      imem_addr <= BASE_ADDR;
      imem_wdata <= '0;
      words <= '0;
      illegal <= 1'b0;
    end else begin
      imem_we <= fire & legal;
      if (fire & legal) begin
        imem_addr <= BASE_ADDR + (AW'(words) << 2);
        imem_wdata <= enc;
        words <= words + WW'(1);
      end
      if (fire & ~legal) illegal <= 1'b1;
      if (restart) begin
        words <= '0;
        illegal <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized and directed checks against an offset-based RV32I encoding model
module tb_instr_encoder_loader;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam logic [31:0] BASE = 32'h0;
  typedef struct packed {
    logic [6:0] op; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic [2:0] fn3; logic f7; logic [11:0] imm; logic [19:0] uj; logic last;
  } bundle_t;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, in_last = 0, in_fn7_5 = 0;
  logic in_ready, imem_we, busy, done, illegal;
  logic [6:0] in_opcode = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [2:0] in_fn3 = 0;
  logic [11:0] in_imm = 0;
  logic [19:0] in_imm_uj = 0;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0] words;
  int checks = 0, failures = 0;
  logic [31:0] q_addr[$], q_data[$];
  always #5 clk = ~clk;
  instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_fn3(in_fn3),
    .in_fn7_5(in_fn7_5), .in_imm(in_imm), .in_imm_uj(in_imm_uj), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done), .illegal(illegal),
    .words(words));
  always @(negedge clk) if (imem_we) begin
    q_addr.push_back(imem_addr);
    q_data.push_back(imem_wdata);
  end
  // Reference: B/J fields are rebuilt into true byte offsets, then placed per the ISA layout
  function automatic logic [32:0] ref_enc(input bundle_t b);
    logic [12:0] bo;
    logic [20:0] jo;
    bo = {b.imm, 1'b0};
    jo = {b.uj, 1'b0};
    case (b.op)
      7'h33: return {1'b1, b.f7 ? 7'b0100000 : 7'b0, b.rs2, b.rs1, b.fn3, b.rd, b.op};
      7'h13, 7'h03: return {1'b1, b.imm, b.rs1, b.fn3, b.rd, b.op};
      7'h23: return {1'b1, b.imm[11:5], b.rs2, b.rs1, b.fn3, b.imm[4:0], b.op};
      7'h63: return {1'b1, bo[12], bo[10:5], b.rs2, b.rs1, b.fn3, bo[4:1], bo[11], b.op};
      7'h6F: return {1'b1, jo[20], jo[10:1], jo[11], jo[19:12], b.rd, b.op};
      7'h37: return {1'b1, b.uj, b.rd, b.op};
      default: return 33'h0;
    endcase
  endfunction
  function automatic bundle_t mk(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                 input logic [2:0] fn3, input logic f7, input logic [11:0] imm,
                                 input logic [19:0] uj, input logic last);
    return '{op: op, rd: rd, rs1: rs1, rs2: rs2, fn3: fn3, f7: f7, imm: imm, uj: uj, last: last};
  endfunction
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic send(input bundle_t b, output bit taken);
    in_valid = 1; in_opcode = b.op; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
    in_fn3 = b.fn3; in_fn7_5 = b.f7; in_imm = b.imm; in_imm_uj = b.uj; in_last = b.last;
    taken = in_ready;
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic run_session(input string name, input bundle_t bs[$]);
    logic [31:0] ea[$], ed[$];
    logic [32:0] r;
    int slot = 0;
    bit ill = 0, open = 1, taken;
    q_addr.delete();
    q_data.delete();
    pulse_start();
    foreach (bs[i]) begin
      send(bs[i], taken);
      checks++;
      if (taken !== open) begin
        failures++;
        $display("FAIL %s taken[%0d] got %0b expected %0b", name, i, taken, open);
      end
      if (open) begin
        r = ref_enc(bs[i]);
        if (r[32]) begin
          ea.push_back(BASE + 32'(4 * slot));
          ed.push_back(r[31:0]);
          slot++;
          if (slot == DEPTH) open = 0;
        end else ill = 1;
        if (bs[i].last) open = 0;
      end
    end
    for (int k = 0; k < 8 && done !== 1'b1; k++) @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done/busy got %0b/%0b expected 1/0", name, done, busy);
    end
    checks++;
    if (int'(words) !== slot || illegal !== ill) begin
      failures++;
      $display("FAIL %s words/illegal got %0d/%0b expected %0d/%0b", name, words, illegal, slot, ill);
    end
    checks++;
    if (q_addr.size() !== ea.size()) begin
      failures++;
      $display("FAIL %s write count got %0d expected %0d", name, q_addr.size(), ea.size());
    end else foreach (ea[i]) begin
      checks++;
      if (q_addr[i] !== ea[i] || q_data[i] !== ed[i]) begin
        failures++;
        $display("FAIL %s write[%0d] got %h@%h expected %h@%h", name, i, q_data[i], q_addr[i], ed[i], ea[i]);
      end
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, imem_we, busy, done, illegal} !== 5'b0 || imem_addr !== BASE || imem_wdata !== 32'h0 || words !== 3'd0) begin
      failures++;
      $display("FAIL reset got rdy=%b we=%b busy=%b done=%b ill=%b addr=%h wd=%h words=%0d expected all zero",
               in_ready, imem_we, busy, done, illegal, imem_addr, imem_wdata, words);
    end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_addi();
    bit t;
    pulse_start();
    send(mk(7'h13, 1, 0, 0, 0, 0, 12'd5, 0, 1), t);
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h00500093 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL addi write got we=%b %h@%h busy=%b done=%b expected 1 00500093@0 busy=1 done=0",
               imem_we, imem_wdata, imem_addr, busy, done);
    end
    @(negedge clk);
    checks++;
    if (imem_we !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || words !== 3'd1) begin
      failures++;
      $display("FAIL addi done got we=%b done=%b busy=%b words=%0d expected 0 1 0 1", imem_we, done, busy, words);
    end
  endtask
  task automatic test_back_to_back();
    bit t;
    pulse_start();
    send(mk(7'h33, 3, 1, 2, 0, 1, 0, 0, 0), t);
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h402081B3) begin
      failures++;
      $display("FAIL b2b sub got we=%b %h@%h expected 1 402081b3@0", imem_we, imem_wdata, imem_addr);
    end
    send(mk(7'h23, 0, 1, 2, 2, 0, 12'd8, 0, 1), t);
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h4 || imem_wdata !== 32'h0020A423) begin
      failures++;
      $display("FAIL b2b sw got we=%b %h@%h expected 1 0020a423@4", imem_we, imem_wdata, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || words !== 3'd2) begin
      failures++;
      $display("FAIL b2b done got done=%b words=%0d expected 1 2", done, words);
    end
  endtask
  task automatic test_formats();
    bundle_t bs[$];
    logic [31:0] exp_w[3] = '{32'h00208463, 32'h010000EF, 32'h123452B7};
    bs = '{mk(7'h63, 0, 1, 2, 0, 0, 12'h004, 0, 0), mk(7'h6F, 1, 0, 0, 0, 0, 0, 20'h00008, 0),
           mk(7'h37, 5, 0, 0, 0, 0, 0, 20'h12345, 1)};
    run_session("formats", bs);
    foreach (exp_w[i]) begin
      checks++;
      if (q_data.size() <= i || q_data[i] !== exp_w[i]) begin
        failures++;
        $display("FAIL formats const[%0d] got %h expected %h", i, q_data.size() > i ? q_data[i] : 32'hx, exp_w[i]);
      end
    end
  endtask
  task automatic test_illegal();
    bundle_t bs[$];
    bs = '{mk(7'h13, 1, 0, 0, 0, 0, 12'd1, 0, 0), mk(7'h7F, 2, 3, 4, 1, 1, 12'hFFF, 20'hFFFFF, 0),
           mk(7'h13, 2, 0, 0, 0, 0, 12'd2, 0, 1)};
    run_session("illegal", bs);
    checks++;
    if (illegal !== 1'b1 || words !== 3'd2 || q_addr.size() != 2 || q_addr[1] !== 32'h4) begin
      failures++;
      $display("FAIL illegal const got ill=%b words=%0d writes=%0d expected 1 2 2 (second @4)", illegal, words, q_addr.size());
    end
  endtask
  task automatic test_full();
    bundle_t bs[$];
    for (int i = 0; i < 6; i++) bs.push_back(mk(7'h13, 5'(i + 1), 0, 0, 0, 0, 12'(i), 0, 0));
    run_session("full", bs);
    checks++;
    if (words !== 3'd4 || in_ready !== 1'b0 || q_addr.size() != 4 || q_addr[3] !== 32'hC) begin
      failures++;
      $display("FAIL full const got words=%0d rdy=%b writes=%0d expected 4 0 4 (last @c)", words, in_ready, q_addr.size());
    end
  endtask
  task automatic test_start_ignored();
    bit t;
    q_addr.delete();
    pulse_start();
    send(mk(7'h13, 1, 0, 0, 0, 0, 12'd1, 0, 0), t);
    start = 1;
    send(mk(7'h13, 2, 0, 0, 0, 0, 12'd2, 0, 0), t);
    start = 0;
    send(mk(7'h13, 3, 0, 0, 0, 0, 12'd3, 0, 1), t);
    @(negedge clk);
    #1;
    checks++;
    if (words !== 3'd3 || done !== 1'b1 || q_addr.size() != 3 || q_addr[2] !== 32'h8) begin
      failures++;
      $display("FAIL start_ignored got words=%0d done=%b writes=%0d expected 3 1 3 (last @8)", words, done, q_addr.size());
    end
  endtask
  task automatic test_rst_mid();
    bundle_t bs[$];
    bit t;
    pulse_start();
    send(mk(7'h7F, 0, 0, 0, 0, 0, 0, 0, 0), t);
    send(mk(7'h13, 1, 0, 0, 0, 0, 12'd7, 0, 0), t);
    rst = 1;
    @(negedge clk);
    checks++;
    if ({in_ready, imem_we, busy, done, illegal} !== 5'b0 || imem_addr !== BASE || imem_wdata !== 32'h0 || words !== 3'd0) begin
      failures++;
      $display("FAIL rst_mid got rdy=%b we=%b busy=%b done=%b ill=%b addr=%h wd=%h words=%0d expected reset values",
               in_ready, imem_we, busy, done, illegal, imem_addr, imem_wdata, words);
    end
    rst = 0;
    bs = '{mk(7'h37, 7, 0, 0, 0, 0, 0, 20'hABCDE, 1)};
    run_session("rst_restart", bs);
    checks++;
    if (q_addr.size() != 1 || q_addr[0] !== BASE) begin
      failures++;
      $display("FAIL rst_restart addr got %0d writes expected one at %h", q_addr.size(), BASE);
    end
  endtask
  task automatic test_random();
    logic [6:0] ops[7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37};
    for (int s = 0; s < 25; s++) begin
      bundle_t bs[$];
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        logic [6:0] op = $urandom_range(0, 4) == 0 ? 7'($urandom) : ops[$urandom_range(0, 6)];
        bs.push_back(mk(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom),
                        12'($urandom), 20'($urandom), i == n - 1 || $urandom_range(0, 5) == 0));
      end
      run_session($sformatf("random%0d", s), bs);
    end
  endtask
  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_formats();
    test_illegal();
    test_full();
    test_start_ignored();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
